// File: rtl/multicycle_control.sv
// Moore FSM sequencing a shared-memory multicycle MIPS datapath: decodes OpCode
// into per-cycle selects/enables, with MEM_WAIT extra cycles per memory access state.
module multicycle_control #(
  parameter int unsigned MEM_WAIT = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] OpCode,
  input  logic       Zero,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegDst,
  output logic       MemToReg,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic [1:0] PCSrc,
  output logic       PCEn,
  output logic       IllegalOp,
  output logic [3:0] State
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_ADDIEX = 4'd9,
    S_ADDIWB = 4'd10,
    S_JUMP   = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [3:0] LP_WAIT  = MEM_WAIT[3:0];

  state_t     r_state;
  state_t     w_next;
  logic [3:0] r_cnt;
  logic       w_in_mem;
  logic       w_mem_done;
  logic       w_mem_rd;
  logic       w_mem_wr;
  logic       w_ir_write;
  logic       w_reg_write;
  logic       w_pc_write;
  logic       w_branch;
  logic       w_bne;
  logic       w_illegal;

  assign w_in_mem   = (r_state == S_FETCH) || (r_state == S_MEMRD) || (r_state == S_MEMWR);
  assign w_mem_done = (r_cnt == LP_WAIT);

  // Counter leaves every memory state at zero, so each entry starts a fresh wait.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_FETCH;
      r_cnt   <= 4'd0;
    end else begin
      r_state <= w_next;
      r_cnt   <= (w_in_mem && !w_mem_done) ? r_cnt + 4'd1 : 4'd0;
    end
  end

  always_comb begin
    w_next      = S_FETCH;
    IorD        = 1'b0;
    w_mem_rd    = 1'b0;
    w_mem_wr    = 1'b0;
    w_ir_write  = 1'b0;
    RegDst      = 1'b0;
    MemToReg    = 1'b0;
    w_reg_write = 1'b0;
    ALUSrcA     = 1'b0;
    ALUSrcB     = 2'b00;
    ALUOp       = 2'b00;
    PCSrc       = 2'b00;
    w_pc_write  = 1'b0;
    w_branch    = 1'b0;
    w_bne       = 1'b0;
    w_illegal   = 1'b0;
    case (r_state)
      S_FETCH: begin
        w_mem_rd = 1'b1;
        ALUSrcB  = 2'b01;
        if (w_mem_done) begin
          w_ir_write = 1'b1;
          w_pc_write = 1'b1;
          w_next     = S_DECODE;
        end else begin
          w_next = S_FETCH;
        end
      end
      S_DECODE: begin
        ALUSrcB = 2'b11;
        case (OpCode)
          OP_LW, OP_SW:   w_next = S_MEMADR;
          OP_RTYPE:       w_next = S_EXEC;
          OP_BEQ, OP_BNE: w_next = S_BRANCH;
          OP_ADDI:        w_next = S_ADDIEX;
          OP_J:           w_next = S_JUMP;
          default: begin
            w_illegal = 1'b1;
            w_next    = S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        if (OpCode == OP_LW)      w_next = S_MEMRD;
        else if (OpCode == OP_SW) w_next = S_MEMWR;
        else                      w_next = S_FETCH;
      end
      S_MEMRD: begin
        IorD     = 1'b1;
        w_mem_rd = 1'b1;
        w_next   = w_mem_done ? S_MEMWB : S_MEMRD;
      end
      S_MEMWB: begin
        MemToReg    = 1'b1;
        w_reg_write = 1'b1;
      end
      S_MEMWR: begin
        IorD     = 1'b1;
        w_mem_wr = 1'b1;
        w_next   = w_mem_done ? S_FETCH : S_MEMWR;
      end
      S_EXEC: begin
        ALUSrcA = 1'b1;
        ALUOp   = 2'b10;
        w_next  = S_ALUWB;
      end
      S_ALUWB: begin
        RegDst      = 1'b1;
        w_reg_write = 1'b1;
      end
      S_BRANCH: begin
        ALUSrcA  = 1'b1;
        ALUOp    = 2'b01;
        PCSrc    = 2'b01;
        w_branch = (OpCode == OP_BEQ);
        w_bne    = (OpCode == OP_BNE);
      end
      S_ADDIEX: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        w_next  = S_ADDIWB;
      end
      S_ADDIWB: w_reg_write = 1'b1;
      S_JUMP: begin
        PCSrc      = 2'b10;
        w_pc_write = 1'b1;
      end
      default: w_next = S_FETCH;
    endcase
  end

  // Side-effecting strobes are masked while reset is held so an abandoned access never commits.
  assign MemRead   = w_mem_rd & ~reset;
  assign MemWrite  = w_mem_wr & ~reset;
  assign IRWrite   = w_ir_write & ~reset;
  assign RegWrite  = w_reg_write & ~reset;
  assign IllegalOp = w_illegal & ~reset;
  assign PCEn      = (w_pc_write | (w_branch & Zero) | (w_bne & ~Zero)) & ~reset;
  assign State     = r_state;

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: three instances (MEM_WAIT 0, 2, 3) checked cycle by cycle
// against an instruction-level model that expands each opcode into its expected cycle list.
module tb_multicycle_control;

  logic       clk = 1'b0;
  logic       rst [3];
  logic [5:0] op  [3];
  logic       zr  [3];
  logic [19:0] obs [3];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int unsigned W = (g == 0) ? 0 : (g == 1) ? 2 : 3;
    logic       iord, mrd, mwr, irw, rdst, m2r, rw, asa, pcen, ill;
    logic [1:0] asb, aop, pcs;
    logic [3:0] st;
    multicycle_control #(.MEM_WAIT(W)) u_dut (
      .clk(clk), .reset(rst[g]), .OpCode(op[g]), .Zero(zr[g]),
      .IorD(iord), .MemRead(mrd), .MemWrite(mwr), .IRWrite(irw),
      .RegDst(rdst), .MemToReg(m2r), .RegWrite(rw), .ALUSrcA(asa),
      .ALUSrcB(asb), .ALUOp(aop), .PCSrc(pcs), .PCEn(pcen),
      .IllegalOp(ill), .State(st)
    );
    assign obs[g] = {st, iord, mrd, mwr, irw, rdst, m2r, rw, asa, asb, aop, pcs, pcen, ill};
  end

  typedef struct {
    logic [19:0] exp;
    bit          fetch;
    bit          br;
    bit          z;
  } cyc_t;

  cyc_t       q[$];
  logic [5:0] cur_op;
  int         checks = 0;
  int         errors = 0;

  localparam logic [5:0] LW = 6'h23, SW = 6'h2b, RT = 6'h00, BEQ = 6'h04,
                         BNE = 6'h05, ADDI = 6'h08, J = 6'h02;

  function automatic int wait_of(input int g);
    return (g == 0) ? 0 : (g == 1) ? 2 : 3;
  endfunction

  function automatic logic [19:0] v(input logic [3:0] st, input bit iord, mrd, mwr, irw,
                                    rdst, m2r, rw, asa, input logic [1:0] asb, aop, pcs,
                                    input bit pcen, ill);
    return {st, iord, mrd, mwr, irw, rdst, m2r, rw, asa, asb, aop, pcs, pcen, ill};
  endfunction

  task automatic push(input logic [19:0] e, input bit f, input bit br, input bit z);
    cyc_t c;
    c.exp = e; c.fetch = f; c.br = br; c.z = z;
    q.push_back(c);
  endtask

  // Expand one instruction into the cycle-by-cycle outputs it should produce.
  task automatic build(input logic [5:0] opc, input int w, input bit z);
    bit legal;
    q.delete();
    cur_op = opc;
    legal  = opc inside {LW, SW, RT, BEQ, BNE, ADDI, J};
    for (int k = 0; k <= w; k++)
      push(v(0, 0, 1, 0, k == w, 0, 0, 0, 0, 2'b01, 2'b00, 2'b00, k == w, 0), 1, 0, 0);
    push(v(1, 0, 0, 0, 0, 0, 0, 0, 0, 2'b11, 2'b00, 2'b00, 0, !legal), 0, 0, 0);
    case (opc)
      LW: begin
        push(v(2, 0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 2'b00, 2'b00, 0, 0), 0, 0, 0);
        for (int k = 0; k <= w; k++)
          push(v(3, 1, 1, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 0, 0), 0, 0, 0);
        push(v(4, 0, 0, 0, 0, 0, 1, 1, 0, 2'b00, 2'b00, 2'b00, 0, 0), 0, 0, 0);
      end
      SW: begin
        push(v(2, 0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 2'b00, 2'b00, 0, 0), 0, 0, 0);
        for (int k = 0; k <= w; k++)
          push(v(5, 1, 0, 1, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 0, 0), 0, 0, 0);
      end
      RT: begin
        push(v(6, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b10, 2'b00, 0, 0), 0, 0, 0);
        push(v(7, 0, 0, 0, 0, 1, 0, 1, 0, 2'b00, 2'b00, 2'b00, 0, 0), 0, 0, 0);
      end
      BEQ, BNE:
        push(v(8, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b01, 2'b01,
               (opc == BEQ) ? z : !z, 0), 0, 1, z);
      ADDI: begin
        push(v(9, 0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 2'b00, 2'b00, 0, 0), 0, 0, 0);
        push(v(10, 0, 0, 0, 0, 0, 0, 1, 0, 2'b00, 2'b00, 2'b00, 0, 0), 0, 0, 0);
      end
      J: push(v(11, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b10, 1, 0), 0, 0, 0);
      default: ;
    endcase
  endtask

  task automatic chk(input int g, input logic [19:0] e, input string tag);
    checks++;
    assert (obs[g] === e)
    else begin
      errors++;
      $error("FAIL %s inst=%0d observed=%h expected=%h", tag, g, obs[g], e);
    end
  endtask

  // Drive and check the first n cycles of the queued instruction (all of them when n < 0).
  task automatic run(input int g, input int n, input string tag);
    for (int i = 0; i < q.size() && (n < 0 || i < n); i++) begin
      @(posedge clk);
      #1;
      rst[g] = 1'b0;
      op[g]  = q[i].fetch ? 6'($urandom) : cur_op;
      zr[g]  = q[i].br ? q[i].z : 1'($urandom);
      @(negedge clk);
      chk(g, q[i].exp, tag);
    end
  endtask

  task automatic do_reset(input int g);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      rst[g] = 1'b1;
      op[g]  = 6'($urandom);
      zr[g]  = 1'($urandom);
      @(negedge clk);
      chk(g, v(0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b01, 2'b00, 2'b00, 0, 0), "reset");
    end
  endtask

  logic [5:0] pool [7] = '{LW, SW, RT, BEQ, BNE, ADDI, J};
  logic [5:0] rop;

  initial begin
    for (int g = 0; g < 3; g++) begin
      rst[g] = 1'b1;
      op[g]  = 6'd0;
      zr[g]  = 1'b0;
    end

    do_reset(0);
    build(RT, 0, 0);          run(0, -1, "rtype");
    build(BEQ, 0, 1);         run(0, -1, "beq_z1");
    build(BEQ, 0, 0);         run(0, -1, "beq_z0");
    build(BNE, 0, 0);         run(0, -1, "bne_z0");
    build(BNE, 0, 1);         run(0, -1, "bne_z1");
    build(6'b111111, 0, 0);   run(0, -1, "illegal");
    build(ADDI, 0, 0);        run(0, -1, "addi");
    build(J, 0, 0);           run(0, -1, "jump");
    build(LW, 0, 0);          run(0, -1, "lw_w0");
    build(SW, 0, 0);          run(0, -1, "sw_w0");
    do_reset(0);

    do_reset(1);
    build(LW, 2, 0);          run(1, -1, "lw_w2");
    build(SW, 2, 0);          run(1, -1, "sw_w2");
    do_reset(1);

    do_reset(2);
    build(SW, 3, 0);          run(2, 7, "sw_w3_pre");
    @(posedge clk);
    #1;
    rst[2] = 1'b1;
    @(negedge clk);
    chk(2, v(5, 1, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 0, 0), "memwr_reset");
    build(RT, 3, 0);          run(2, -1, "after_reset");
    do_reset(2);

    for (int g = 0; g < 3; g++) begin
      do_reset(g);
      for (int n = 0; n < 30; n++) begin
        if ($urandom_range(0, 3) == 0) rop = 6'($urandom);
        else                           rop = pool[$urandom_range(0, 6)];
        build(rop, wait_of(g), 1'($urandom));
        run(g, -1, "random");
      end
      do_reset(g);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Moore FSM controller that sequences the shared multicycle MIPS datapath. One memory, one ALU, IR/A/B/ALUOut registers.
- Decodes OpCode from the instruction register and produces per-cycle mux selects and write enables.
- Gates the PC write enable with the ALU Zero flag for beq/bne.
- Supports configurable memory wait cycles and flags unsupported opcodes.

Parameters:
- MEM_WAIT, 0, extra cycles spent in each memory-access state (FETCH, MEMRD, MEMWR); 0..15.

Ports:
- clk  input  1  system clock, all state changes on rising edge
- reset  input  1  synchronous, active-high reset
- OpCode  input  6  instr[31:26] from the instruction register
- Zero  input  1  ALU zero flag
- IorD  output  1  memory address select: 0=PC, 1=ALUOut
- MemRead  output  1  memory read enable
- MemWrite  output  1  memory write enable
- IRWrite  output  1  instruction register load
- RegDst  output  1  write register select: 0=rt, 1=rd
- MemToReg  output  1  write-back select: 0=ALUOut, 1=MDR
- RegWrite  output  1  register file write
- ALUSrcA  output  1  ALU A select: 0=PC, 1=A
- ALUSrcB  output  2  ALU B select: 00=B, 01=4, 10=signext, 11=signext<<2
- ALUOp  output  2  00=add, 01=sub, 10=funct decode
- PCSrc  output  2  PC source: 00=ALU, 01=ALUOut, 10=jump target
- PCEn  output  1  PC register enable
- IllegalOp  output  1  one-cycle pulse on an unsupported opcode
- State  output  4  current state encoding, for debug

Behaviour:
- State encoding: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, ALUWB=7, BRANCH=8, ADDIEX=9, ADDIWB=10, JUMP=11. Codes 12-15 go to FETCH on the next edge.
- Reset: State=FETCH, wait counter=0.
  - While reset=1, MemRead, MemWrite, IRWrite, RegWrite, PCEn and IllegalOp are forced to 0.
  - Reset asserted mid-instruction abandons it; the next state is FETCH.
- Any output not listed for a state is 0.
- Per-state outputs:
  - FETCH: MemRead=1, ALUSrcB=01. IRWrite=1 and PCWrite=1 only when cnt==MEM_WAIT.
  - DECODE: ALUSrcB=11. Next state by opcode:
    - 100011 (lw) / 101011 (sw) -> MEMADR
    - 000000 (R-type) -> EXEC
    - 000100 (beq) / 000101 (bne) -> BRANCH
    - 001000 (addi) -> ADDIEX
    - 000010 (j) -> JUMP
    - anything else -> FETCH, with IllegalOp=1 for that DECODE cycle
  - MEMADR: ALUSrcA=1, ALUSrcB=10, ALUOp=00. Next: MEMRD if lw, MEMWR if sw.
  - MEMRD: IorD=1, MemRead=1 every wait cycle. Leaves to MEMWB when cnt==MEM_WAIT.
  - MEMWB: MemToReg=1, RegWrite=1. Next: FETCH.
  - MEMWR: IorD=1, MemWrite=1 every wait cycle. Leaves to FETCH when cnt==MEM_WAIT.
  - EXEC: ALUSrcA=1, ALUOp=10. Next: ALUWB.
  - ALUWB: RegDst=1, RegWrite=1. Next: FETCH.
  - BRANCH: ALUSrcA=1, ALUOp=01, PCSrc=01.
    - Internal Branch=1 if OpCode=beq; internal Bne=1 if OpCode=bne.
    - Next: FETCH.
  - ADDIEX: ALUSrcA=1, ALUSrcB=10. Next: ADDIWB.
  - ADDIWB: RegWrite=1 (RegDst=0, MemToReg=0). Next: FETCH.
  - JUMP: PCSrc=10, PCWrite=1. Next: FETCH.
- PCEn is combinational: PCWrite | (Branch & Zero) | (Bne & ~Zero).
- Wait counter (4-bit):
  - Clears on entry to any memory state.
  - Increments each cycle in a memory state while cnt<MEM_WAIT.
  - The state advances on the cycle with cnt==MEM_WAIT. MEM_WAIT=0 means a single-cycle memory state.
- OpCode is sampled only in DECODE, MEMADR and BRANCH; the IR is stable after FETCH.
- Cycles per instruction with MEM_WAIT=0: lw 5, sw 4, R-type 4, addi 4, beq/bne 3, j 3, illegal 2.
  - Each memory state adds MEM_WAIT cycles. Fetch is always counted; lw and sw add one more memory state.

Test Plan:
- Reset held 3 cycles, then released -> enables 0 during reset; State=0 and MemRead=1, IRWrite=1, PCEn=1 on the first cycle after release (MEM_WAIT=0).
- R-type (OpCode=000000) -> States 0,1,6,7,0; RegDst=1, RegWrite=1 in state 7 only; 4 cycles total.
- lw then sw, MEM_WAIT=2 -> lw takes 5+2+2=9 cycles, with MemRead held 3 cycles in MEMRD; sw takes 4+2+2=8 cycles, with MemWrite held 3 cycles and IRWrite pulsing once per fetch.
- beq with Zero=1 then Zero=0; bne with Zero=0 then Zero=1 -> PCEn=1 in BRANCH only for beq/Zero=1 and bne/Zero=0, with PCSrc=01.
- OpCode=111111 -> IllegalOp=1 for exactly the DECODE cycle, then FETCH; no RegWrite or MemWrite asserted.
- Reset asserted in MEMWR mid-wait (MEM_WAIT=3) -> MemWrite drops that cycle; State=FETCH after release; counter restarts from 0.
